arm_pipelined_fetch_unit: RTL
=============================

ARM_PIPELINED_FETCH_UNIT -- requirements
Module: arm_pipelined_fetch_unit

Interface
REQ-001 Parameters SHALL be: BusWidth, 32, datapath/address width; QDepth, 2, instruction queue entries; ResetVector, 32'h0000_0000, first fetch address.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 Ports SHALL be (name direction width meaning):
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous active-high reset.
- imem_req  out  1  fetch request valid.
- imem_addr  out  BusWidth  word-aligned fetch address.
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  read data valid.
- imem_rdata  in  BusWidth  returned instruction.
- redirect  in  1  branch/PC-write redirect from the conditional/PC logic.
- redirect_pc  in  BusWidth  redirect target.
- dec_ready  in  1  decode stage accepts the head instruction.
- if_valid  out  1  head instruction valid to decode.
- if_instr  out  BusWidth  head instruction word.
- if_pc  out  BusWidth  address of head instruction.
- if_pc_plus8  out  BusWidth  if_pc+8, the R15 read value.

Function
REQ-004 The FSM SHALL have states IDLE, WAIT (one request outstanding), DROP (outstanding response to be discarded); at most one request SHALL be outstanding.
REQ-005 imem_req SHALL be 1 iff state==IDLE, redirect==0, and queue count < QDepth; imem_addr SHALL equal fetch PC, held stable until imem_gnt.
REQ-006 On imem_req&&imem_gnt: state->WAIT, fetch PC <= PC+4 (mod 2^32), issued PC recorded with the request.
REQ-007 In WAIT with imem_rvalid and no redirect: {imem_rdata, issued PC} SHALL be pushed into the queue, state->IDLE; minimum request-to-data latency is 1 cycle.
REQ-008 imem_rvalid in IDLE SHALL be ignored.
REQ-009 if_valid SHALL equal queue-not-empty; if_instr/if_pc SHALL be the head entry; head SHALL pop when if_valid&&dec_ready.
REQ-010 Push and pop in the same cycle SHALL leave count unchanged; push into a full queue SHALL be impossible by REQ-005.
REQ-011 redirect SHALL have highest priority: queue cleared, fetch PC <= {redirect_pc[31:2],2'b00}, if_valid=0 next cycle, no pop recorded that cycle.
REQ-012 redirect in WAIT without imem_rvalid SHALL move to DROP; redirect in WAIT with imem_rvalid SHALL discard the data and move to IDLE.
REQ-013 In DROP, imem_rvalid SHALL discard data and move to IDLE; redirect in DROP SHALL update fetch PC and stay in DROP.
REQ-014 Throughput with 1-cycle memory and dec_ready=1 SHALL be one instruction per 2 cycles; the FSM SHALL not deadlock under any gnt/rvalid delay.

Reset
REQ-015 On reset: state IDLE, fetch PC=ResetVector, queue empty, imem_req=0, if_valid=0, if_instr=0, if_pc=0, if_pc_plus8=8.
REQ-016 Reset in WAIT/DROP SHALL abandon the outstanding request; its late response is ignored per REQ-008.
REQ-017 First imem_req SHALL assert in the first cycle after reset deasserts.

Structure
REQ-018 Package arm_pipelined_pkg SHALL hold the fetch state enum, the queue-entry struct {instr, pc}, and constant InstrBytes=4.
REQ-019 The queue SHALL be sub-module arm_pipelined_fetch_queue (sync FIFO, push/pop/clear, count output); PC and FSM stay in the top.

Verification
REQ-020 Reset, gnt=1, 1-cycle rvalid, dec_ready=1 -> imem_addr 0x0,0x4,0x8; if_pc 0x0 with if_pc_plus8 0x8, instructions in order.
REQ-021 dec_ready=0 for 10 cycles -> queue fills to 2, imem_req=0, no data lost; release -> entries 0x0,0x4 delivered in order.
REQ-022 redirect to 0x103 while WAIT, response 3 cycles later -> response discarded, next imem_addr 0x100, first if_pc 0x100.
REQ-023 redirect coinciding with imem_rvalid -> data discarded, IDLE, fetch from redirect_pc next cycle.
REQ-024 reset asserted in WAIT, stray rvalid 2 cycles later -> ignored, fetch restarts at ResetVector.
REQ-025 Fetch PC 0xFFFF_FFFC -> next imem_addr 0x0000_0000.

Source files
------------

// File: rtl/arm_pipelined_pkg.sv
// Shared types and constants for the ARM pipelined instruction fetch unit.
// The fetch queue entry is fixed at 32-bit instruction and 32-bit PC fields.
package arm_pipelined_pkg;

    localparam int unsigned XLen       = 32;
    localparam int unsigned InstrBytes = 4;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_WAIT = 2'd1,
        FETCH_DROP = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [XLen-1:0] instr;
        logic [XLen-1:0] pc;
    } fetch_entry_t;

    // Clears the byte-offset bits so that every fetch address is word aligned.
    function automatic logic [XLen-1:0] word_align(input logic [XLen-1:0] addr);
        return addr & ~XLen'(InstrBytes - 1);
    endfunction

endpackage

// File: rtl/arm_pipelined_fetch_queue.sv
// Synchronous FIFO that holds fetched {instr, pc} entries for decode.
// A clear empties the FIFO and has priority over push and pop.
module arm_pipelined_fetch_queue
    import arm_pipelined_pkg::*;
#(
    parameter int unsigned Depth = 2,
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1,
    localparam int unsigned CntW = $clog2(Depth + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clear_i,
    input  logic            push_i,
    input  fetch_entry_t    push_data_i,
    input  logic            pop_i,
    output fetch_entry_t    head_o,
    output logic [CntW-1:0] count_o
);

    fetch_entry_t    mem_q [Depth];
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [CntW-1:0] count_q;
    logic [PtrW-1:0] wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_d;
    logic [CntW-1:0] count_d;
    logic            do_push_s;
    logic            do_pop_s;

    assign do_push_s = push_i && (count_q < CntW'(Depth));
    assign do_pop_s  = pop_i && (count_q != CntW'(0));

    // Pointer wrap and occupancy bookkeeping.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push_s) begin
            wr_ptr_d = (wr_ptr_q == PtrW'(Depth - 1)) ? PtrW'(0) : wr_ptr_q + PtrW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = (rd_ptr_q == PtrW'(Depth - 1)) ? PtrW'(0) : rd_ptr_q + PtrW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage and pointer registers; storage is zeroed on reset so the head reads 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push_s) begin
                mem_q[wr_ptr_q] <= push_data_i;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/arm_pipelined_fetch_unit.sv
// Instruction fetch front end: single-outstanding memory FSM, fetch PC and a
// small instruction queue feeding decode. BusWidth must match the package XLen.
module arm_pipelined_fetch_unit
    import arm_pipelined_pkg::*;
#(
    parameter int unsigned         BusWidth    = 32,
    parameter int unsigned         QDepth      = 2,
    parameter logic [BusWidth-1:0] ResetVector = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                reset,
    output logic                imem_req,
    output logic [BusWidth-1:0] imem_addr,
    input  logic                imem_gnt,
    input  logic                imem_rvalid,
    input  logic [BusWidth-1:0] imem_rdata,
    input  logic                redirect,
    input  logic [BusWidth-1:0] redirect_pc,
    input  logic                dec_ready,
    output logic                if_valid,
    output logic [BusWidth-1:0] if_instr,
    output logic [BusWidth-1:0] if_pc,
    output logic [BusWidth-1:0] if_pc_plus8
);

    localparam int unsigned CntW = $clog2(QDepth + 1);

    fetch_state_e        state_q;
    fetch_state_e        state_d;
    logic [BusWidth-1:0] fetch_pc_q;
    logic [BusWidth-1:0] fetch_pc_d;
    logic [BusWidth-1:0] issued_pc_q;
    logic [BusWidth-1:0] issued_pc_d;
    logic                req_s;
    logic                q_push_s;
    logic                q_pop_s;
    logic                q_clear_s;
    logic [CntW-1:0]     q_count_s;
    fetch_entry_t        q_head_s;
    fetch_entry_t        q_push_data_s;

    assign req_s         = (state_q == FETCH_IDLE) && !redirect && !reset &&
                           (q_count_s < CntW'(QDepth));
    assign q_push_data_s = '{instr: imem_rdata, pc: issued_pc_q};
    assign q_pop_s       = if_valid && dec_ready && !redirect;

    // Next-state logic; redirect wins and any in-flight response is dropped.
    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        issued_pc_d = issued_pc_q;
        q_push_s    = 1'b0;
        q_clear_s   = 1'b0;
        if (redirect) begin
            q_clear_s  = 1'b1;
            fetch_pc_d = word_align(redirect_pc);
            case (state_q)
                FETCH_WAIT, FETCH_DROP: state_d = imem_rvalid ? FETCH_IDLE : FETCH_DROP;
                default:                state_d = FETCH_IDLE;
            endcase
        end else begin
            case (state_q)
                FETCH_IDLE: begin
                    if (req_s && imem_gnt) begin
                        state_d     = FETCH_WAIT;
                        fetch_pc_d  = fetch_pc_q + BusWidth'(InstrBytes);
                        issued_pc_d = fetch_pc_q;
                    end else begin
                        state_d = FETCH_IDLE;
                    end
                end
                FETCH_WAIT: begin
                    if (imem_rvalid) begin
                        q_push_s = 1'b1;
                        state_d  = FETCH_IDLE;
                    end else begin
                        state_d = FETCH_WAIT;
                    end
                end
                FETCH_DROP: begin
                    if (imem_rvalid) begin
                        state_d = FETCH_IDLE;
                    end else begin
                        state_d = FETCH_DROP;
                    end
                end
                default: state_d = FETCH_IDLE;
            endcase
        end
    end

    // FSM and PC registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= FETCH_IDLE;
            fetch_pc_q  <= ResetVector;
            issued_pc_q <= '0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            issued_pc_q <= issued_pc_d;
        end
    end

    arm_pipelined_fetch_queue #(
        .Depth(QDepth)
    ) u_queue (
        .clk        (clk),
        .reset      (reset),
        .clear_i    (q_clear_s),
        .push_i     (q_push_s),
        .push_data_i(q_push_data_s),
        .pop_i      (q_pop_s),
        .head_o     (q_head_s),
        .count_o    (q_count_s)
    );

    assign imem_req    = req_s;
    assign imem_addr   = fetch_pc_q;
    assign if_valid    = (q_count_s != CntW'(0));
    assign if_instr    = if_valid ? q_head_s.instr : '0;
    assign if_pc       = if_valid ? q_head_s.pc : '0;
    assign if_pc_plus8 = if_pc + BusWidth'(2 * InstrBytes);

endmodule
